// File: rtl/fc_lif_accum.sv
// LIF membrane accumulator for EC_SIZE parallel neurons fed by a spike-address stream; writes per-step spike words.
// Latency: en_accum -> membrane visible +3 cycles; new_spk_train_ready -> spike RAM write +3 (+4 if same-cycle en_accum).
// Backpressure: none; one event per cycle accepted back-to-back, inputs ignored once the layer is done.
// Optional: define FC_LIF_SPK_CNT_EN to add per-lane fire counters reported at each group end.
module fc_lif_accum #(
   parameter int TIME_STEPS = 10,
   parameter int EC_SIZE    = 4,
   parameter int LAYER_SIZE = 32,
   parameter int INPUT_SIZE = 240,
   parameter int W_WIDTH    = 8,
   parameter int MEM_WIDTH  = 16,
   parameter int THRESHOLD  = 64,
   parameter int LEAK_SHIFT = 3
) (
   input  logic                                            clk,
   input  logic                                            rst,
   input  logic                                            en_accum,
   input  logic [$clog2(INPUT_SIZE)-1:0]                   spk_addr,
   input  logic                                            new_spk_train_ready,
   input  logic                                            last_time_step,
   input  logic [$clog2(TIME_STEPS)+1:0]                   spk_time_step,
   input  logic [$clog2(LAYER_SIZE)-1:0]                   neuron,
   output logic                                            w_rd_en,
   output logic [$clog2(LAYER_SIZE/EC_SIZE*INPUT_SIZE)-1:0] w_addr,
   input  logic [EC_SIZE*W_WIDTH-1:0]                      w_rdata,
   output logic                                            spk_ram_we,
   output logic [$clog2(TIME_STEPS*LAYER_SIZE/EC_SIZE)-1:0] spk_ram_addr,
   output logic [EC_SIZE-1:0]                              spk_out,
`ifdef FC_LIF_SPK_CNT_EN
   output logic [EC_SIZE*($clog2(TIME_STEPS)+1)-1:0]       spk_cnt_out,
   output logic                                            spk_cnt_valid,
`endif
   output logic                                            layer_done
);

   localparam int GROUPS = LAYER_SIZE / EC_SIZE;
   localparam int TS_W   = $clog2(TIME_STEPS) + 2;
   localparam int N_W    = $clog2(LAYER_SIZE);
   localparam int WA_W   = $clog2(GROUPS * INPUT_SIZE);
   localparam int RA_W   = $clog2(TIME_STEPS * GROUPS);
   localparam logic signed [MEM_WIDTH-1:0] THR     = MEM_WIDTH'(THRESHOLD);
   localparam logic signed [MEM_WIDTH-1:0] MEM_MAX = {1'b0, {(MEM_WIDTH-1){1'b1}}};
   localparam logic signed [MEM_WIDTH-1:0] MEM_MIN = {1'b1, {(MEM_WIDTH-1){1'b0}}};
   localparam logic [N_W-1:0] LAST_NRN = N_W'(LAYER_SIZE - EC_SIZE);

   typedef enum logic [1:0] {IDLE, RUN, GROUP_END, DONE} state_t;
   state_t state_q, state_d;

   logic             accept;
   logic [WA_W-1:0]  w_addr_d;
   logic             rd_en_q, s0_rdy_q, s0_last_q;
   logic [WA_W-1:0]  w_addr_q;
   logic [N_W-1:0]   s0_nrn_q, s1_nrn_q, pnd_nrn_q, act_nrn;
   logic [TS_W-1:0]  s0_ts_q, s1_ts_q, pnd_ts_q, act_ts;
   logic             s1_acc_q, s1_rdy_q, s1_last_q;
   logic             pnd_q, pnd_last_q, pnd_d;
   logic             act_vld, act_last;
   logic signed [MEM_WIDTH-1:0] mem_q [EC_SIZE];
   logic signed [MEM_WIDTH-1:0] mem_d [EC_SIZE];
   logic [EC_SIZE-1:0] fire;
   logic             we_q, done_q;
   logic [EC_SIZE-1:0] spk_q;
   logic [RA_W-1:0]  raddr_q;

   assign accept   = (state_q != DONE);
   assign w_addr_d = WA_W'((32'(neuron) / EC_SIZE) * INPUT_SIZE + 32'(spk_addr));

   // A ready that arrives together with its own accumulation is deferred one cycle
   // so the activation sees the updated membrane; the deferred one always wins.
   assign act_vld  = pnd_q | (s1_rdy_q & ~s1_acc_q);
   assign pnd_d    = pnd_q ? s1_rdy_q : (s1_rdy_q & s1_acc_q);
   assign act_last = pnd_q ? pnd_last_q : s1_last_q;
   assign act_nrn  = pnd_q ? pnd_nrn_q  : s1_nrn_q;
   assign act_ts   = pnd_q ? pnd_ts_q   : s1_ts_q;

   // Stage 0: capture event/ready and issue the weight read
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_en_q   <= 1'b0;
         w_addr_q  <= '0;
         s0_rdy_q  <= 1'b0;
         s0_last_q <= 1'b0;
         s0_nrn_q  <= '0;
         s0_ts_q   <= '0;
      end else begin
         rd_en_q   <= en_accum & accept;
         w_addr_q  <= w_addr_d;
         s0_rdy_q  <= new_spk_train_ready & accept;
         s0_last_q <= last_time_step;
         s0_nrn_q  <= neuron;
         s0_ts_q   <= spk_time_step;
      end
   end

   // Stage 1: align ready with the returning weight word; hold a deferred ready
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_acc_q   <= 1'b0;
         s1_rdy_q   <= 1'b0;
         s1_last_q  <= 1'b0;
         s1_nrn_q   <= '0;
         s1_ts_q    <= '0;
         pnd_q      <= 1'b0;
         pnd_last_q <= 1'b0;
         pnd_nrn_q  <= '0;
         pnd_ts_q   <= '0;
      end else begin
         s1_acc_q   <= rd_en_q;
         s1_rdy_q   <= s0_rdy_q;
         s1_last_q  <= s0_last_q;
         s1_nrn_q   <= s0_nrn_q;
         s1_ts_q    <= s0_ts_q;
         pnd_q      <= pnd_d;
         pnd_last_q <= s1_last_q;
         pnd_nrn_q  <= s1_nrn_q;
         pnd_ts_q   <= s1_ts_q;
      end
   end

   // Per-lane datapath: activation (threshold, subtractive reset, leak) then saturating add
   for (genvar k = 0; k < EC_SIZE; k++) begin : g_lane
      logic signed [MEM_WIDTH-1:0] m, r, lk, base, sat_v;
      logic signed [MEM_WIDTH:0]   wx, sum;
      assign m        = mem_q[k];
      assign fire[k]  = (m >= THR);
      assign r        = fire[k] ? (m - THR) : m;
      assign lk       = r - (r >>> LEAK_SHIFT);
      assign base     = act_vld ? (act_last ? '0 : lk) : m;
      assign wx       = {{(MEM_WIDTH+1-W_WIDTH){w_rdata[k*W_WIDTH+W_WIDTH-1]}},
                         w_rdata[k*W_WIDTH +: W_WIDTH]};
      assign sum      = {base[MEM_WIDTH-1], base} + wx;
      assign sat_v    = (sum[MEM_WIDTH] != sum[MEM_WIDTH-1]) ?
                        (sum[MEM_WIDTH] ? MEM_MIN : MEM_MAX) : sum[MEM_WIDTH-1:0];
      assign mem_d[k] = s1_acc_q ? sat_v : base;
   end

   // Membrane registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < EC_SIZE; k++) mem_q[k] <= '0;
      end else begin
         for (int k = 0; k < EC_SIZE; k++) mem_q[k] <= mem_d[k];
      end
   end

   // Spike RAM write port and sticky layer completion
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         we_q    <= 1'b0;
         spk_q   <= '0;
         raddr_q <= '0;
         done_q  <= 1'b0;
      end else begin
         we_q <= act_vld;
         if (act_vld) begin
            spk_q   <= fire;
            raddr_q <= RA_W'(32'(act_ts) * GROUPS + 32'(act_nrn) / EC_SIZE);
            if (act_last && (act_nrn == LAST_NRN)) done_q <= 1'b1;
         end
      end
   end

   // Control FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Control FSM next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:      if (en_accum || new_spk_train_ready) state_d = RUN;
         RUN:       if (act_vld && act_last) state_d = GROUP_END;
         GROUP_END: state_d = done_q ? DONE : RUN;
         default:   state_d = DONE;
      endcase
   end

`ifdef FC_LIF_SPK_CNT_EN
   localparam int CNT_W = $clog2(TIME_STEPS) + 1;
   logic [CNT_W-1:0] cnt_q [EC_SIZE];

   // Per-lane fire counters, cleared after being reported at group end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < EC_SIZE; k++) cnt_q[k] <= '0;
      end else if (state_q == GROUP_END) begin
         for (int k = 0; k < EC_SIZE; k++) cnt_q[k] <= '0;
      end else if (act_vld) begin
         for (int k = 0; k < EC_SIZE; k++) cnt_q[k] <= cnt_q[k] + CNT_W'(fire[k]);
      end
   end

   for (genvar k = 0; k < EC_SIZE; k++) begin : g_cnt
      assign spk_cnt_out[k*CNT_W +: CNT_W] = cnt_q[k];
   end
   assign spk_cnt_valid = (state_q == GROUP_END);
`endif

   assign w_rd_en      = rd_en_q;
   assign w_addr       = w_addr_q;
   assign spk_ram_we   = we_q;
   assign spk_ram_addr = raddr_q;
   assign spk_out      = spk_q;
   assign layer_done   = done_q;

endmodule
